// File: rtl/dac_sample_scheduler_pkg.sv
// Shared types and helpers for the DAC sample scheduler.
// The optional statistics counters are enabled by defining DAC_SCHED_STATS_EN.
package dac_sched_pkg;

    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_e;

    // Last count value of the sample-period counter (period is clk_freq/sample_rate cycles).
    function automatic int tick_terminal(input int clk_freq, input int sample_rate);
        return (clk_freq / sample_rate) - 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_sample_scheduler_if.sv
// Producer/DAC-side bus of the sample scheduler; stats signals exist only
// when DAC_SCHED_STATS_EN is defined.
interface dac_sample_scheduler_if #(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 8
);
    logic                                             enable;
    logic [NUM_REQ-1:0]                               req_valid;
    logic [NUM_REQ-1:0][dac_sched_pkg::SAMPLE_W-1:0]  req_data;
    logic [NUM_REQ-1:0]                               req_ready;
    logic [dac_sched_pkg::SAMPLE_W-1:0]               dac_sample;
    logic                                             dac_strobe;
    logic                                             underrun;
    logic [dac_sched_pkg::level_w(FIFO_DEPTH)-1:0]    fifo_level;
`ifdef DAC_SCHED_STATS_EN
    logic [15:0]                                      underrun_count;
    logic [31:0]                                      sample_count;
`endif

    modport slave (
        input  enable, req_valid, req_data,
`ifdef DAC_SCHED_STATS_EN
        output underrun_count, sample_count,
`endif
        output req_ready, dac_sample, dac_strobe, underrun, fifo_level
    );

    modport master (
        output enable, req_valid, req_data,
`ifdef DAC_SCHED_STATS_EN
        input  underrun_count, sample_count,
`endif
        input  req_ready, dac_sample, dac_strobe, underrun, fifo_level
    );

endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; no push-to-pop bypass.
// Depth must be a power of two so the pointers wrap naturally.
module dac_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Round-robin producer arbiter, sample FIFO and rate-paced prime/run player
// feeding the DAC writer. Define DAC_SCHED_STATS_EN for underrun/sample counters.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int CLK_Freq    = 50_000_000,
    parameter int SAMPLE_RATE = 4_000,
    parameter int NUM_REQ     = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    dac_sample_scheduler_if.slave   bus
);
    localparam int LW   = level_w(FIFO_DEPTH);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TERM = tick_terminal(CLK_Freq, SAMPLE_RATE);
    localparam int CW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

    sched_state_e          state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  strobe_q, strobe_d;
    logic                  underrun_q, underrun_d;

    logic [NUM_REQ-1:0]    req_ready;
    logic [PW-1:0]         grant_idx;
    logic                  grant_vld;
    int                    arb_idx;
    logic                  push, pop, full, empty, tick;
    logic [SAMPLE_W-1:0]   head;
    logic [LW-1:0]         level;

    // First valid requester at or after the pointer; nothing granted while full.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!grant_vld && bus.req_valid[arb_idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(arb_idx);
            end
        end
        if (full) grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_vld && (grant_idx == PW'(i));
        end
    end

    assign push = grant_vld;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end

    dac_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (reset),
        .push      (push),
        .push_data (bus.req_data[grant_idx]),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign tick = (state_q == RUN) && (tick_cnt_q == CW'(TERM));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = '0;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = PRIME;
            end
            PRIME: begin
                if (!bus.enable)                     state_d = IDLE;
                else if (level >= LW'(PRIME_LEVEL))  state_d = RUN;
            end
            RUN: begin
                // Disable wins over a tick landing in the same cycle.
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        sample_d = head;
                        strobe_d = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = PRIME;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            tick_cnt_q <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.dac_sample = sample_q;
    assign bus.dac_strobe = strobe_q;
    assign bus.underrun   = underrun_q;
    assign bus.fifo_level = level;

`ifdef DAC_SCHED_STATS_EN
    logic [15:0] urun_cnt_q, urun_cnt_d;
    logic [31:0] smp_cnt_q, smp_cnt_d;

    always_comb begin
        urun_cnt_d = urun_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        if (underrun_q && (urun_cnt_q != 16'hFFFF)) urun_cnt_d = urun_cnt_q + 16'd1;
        if (strobe_q) smp_cnt_d = smp_cnt_q + 32'd1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            urun_cnt_q <= '0;
            smp_cnt_q  <= '0;
        end else begin
            urun_cnt_q <= urun_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
        end
    end

    assign bus.underrun_count = urun_cnt_q;
    assign bus.sample_count   = smp_cnt_q;
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler with a short sample period (10 cycles).
module tb_dac_sample_scheduler;
    import dac_sched_pkg::*;

    localparam int P = 10;

    typedef struct packed {
        logic        is_urun;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_push_cyc = 0;
    int   c_first = 0;
    int   cx = 0;
    int   ev_cyc_q[$];
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] alt_data [4] = '{32'hA000_0001, 32'hB000_0001, 32'hA000_0002, 32'hB000_0002};
    logic [1:0]  alt_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    dac_sample_scheduler_if #(.NUM_REQ(2), .FIFO_DEPTH(8)) bus ();

    dac_sample_scheduler #(
        .CLK_Freq    (40_000),
        .SAMPLE_RATE (4_000),
        .NUM_REQ     (2),
        .FIFO_DEPTH  (8),
        .PRIME_LEVEL (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe/underrun pops one expected entry.
    always @(negedge clk) begin
        if (!rst && (bus.dac_strobe || bus.underrun)) begin
            ev_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: strobe=%0b underrun=%0b at cycle %0d", bus.dac_strobe, bus.underrun, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", {31'b0, bus.underrun}, {31'b0, mon_e.is_urun});
                chk("event_data", bus.dac_sample, mon_e.data);
            end
        end
    end

    // Call just after a rising edge; leaves the bus idle just after the transfer edge.
    task automatic push1(input int p, input logic [31:0] d);
        bus.req_valid    = '0;
        bus.req_valid[p] = 1'b1;
        bus.req_data[p]  = d;
        @(negedge clk);
        chk("push_ready", {30'b0, bus.req_ready}, 32'(1 << p));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        last_push_cyc = cyc;
        exp_q.push_back('{1'b0, d});
    endtask

    task automatic wait_ev(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (ev_cyc_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, {31'b0, ev_cyc_q.size() >= n}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  {30'b0, bus.req_ready}, 32'd0);
        chk("rst_sample", bus.dac_sample, 32'd0);
        chk("rst_strobe", {31'b0, bus.dac_strobe}, 32'd0);
        chk("rst_urun",   {31'b0, bus.underrun}, 32'd0);
        chk("rst_level",  {28'b0, bus.fifo_level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Prime with four samples from producer 0, drain, then underrun.
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) push1(0, 32'h0001_0000 * (i + 1));
        exp_q.push_back('{1'b1, 32'h0004_0000});
        ev_cyc_q.delete();
        wait_ev("t1_events", 5, 6 * P + 10);
        if (ev_cyc_q.size() >= 5) begin
            chk("t1_first_strobe_cyc", ev_cyc_q[0], last_push_cyc + 1 + P);
            for (int i = 1; i < 4; i++) chk("t1_strobe_gap", ev_cyc_q[i] - ev_cyc_q[i-1], P);
            chk("t1_underrun_cyc", ev_cyc_q[4], last_push_cyc + 1 + 5 * P);
        end

        // Back in PRIME: three samples must not start playback.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push1(1, 32'h0005_0000 + 32'h0001_0000 * i);
        ev_cyc_q.delete();
        repeat (3 * P) @(negedge clk);
        #1;
        chk("t3_no_strobe_below_prime", ev_cyc_q.size(), 0);
        chk("t3_level3", {28'b0, bus.fifo_level}, 32'd3);

        // Both producers valid: grants alternate 0,1,0,1.
        @(posedge clk);
        #1;
        bus.req_data[0] = alt_data[0];
        bus.req_data[1] = alt_data[1];
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 2'b11;
            @(negedge clk);
            chk("t2_grant", {30'b0, bus.req_ready}, {30'b0, alt_rdy[k]});
            @(posedge clk);
            #1;
            if (k == 0) c_first = cyc;
            exp_q.push_back('{1'b0, alt_data[k]});
            if (k < 2) bus.req_data[alt_rdy[k] == 2'b01 ? 0 : 1] = alt_data[k + 2];
        end
        bus.req_valid = '0;
        exp_q.push_back('{1'b1, 32'hB000_0002});
        wait_ev("t2_events", 8, 9 * P + 10);
        if (ev_cyc_q.size() >= 8) begin
            chk("t2_first_strobe_cyc", ev_cyc_q[0], c_first + 1 + P);
            chk("t2_underrun_cyc", ev_cyc_q[7], c_first + 1 + 8 * P);
        end

        // Fill to full while disabled.
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        for (int i = 0; i < 8; i++) push1(0, 32'h0000_0100 + i);
        bus.req_valid[0] = 1'b1;
        bus.req_data[0]  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_full_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("t4_level8", {28'b0, bus.fifo_level}, 32'd8);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        ev_cyc_q.delete();
        repeat (2 * P) @(negedge clk);
        #1;
        chk("t4_no_strobe_idle", ev_cyc_q.size(), 0);
        @(posedge clk);
        #1;
        bus.enable = 1'b1;
        cx = cyc;
        wait_ev("t4_events", 3, 4 * P);
        if (ev_cyc_q.size() >= 3) begin
            chk("t4_first_strobe_cyc", ev_cyc_q[0], cx + 2 + P);
            chk("t4_third_strobe_cyc", ev_cyc_q[2], cx + 2 + 3 * P);
        end
        chk("t4_level5", {28'b0, bus.fifo_level}, 32'd5);
        @(negedge clk);
`ifdef DAC_SCHED_STATS_EN
        chk("stats_underruns", {16'b0, bus.underrun_count}, 32'd2);
        chk("stats_samples", bus.sample_count, 32'd14);
`endif

        // Asynchronous reset in RUN with five samples queued.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_sample", bus.dac_sample, 32'd0);
        chk("t5_rst_level",  {28'b0, bus.fifo_level}, 32'd0);
        chk("t5_rst_strobe", {31'b0, bus.dac_strobe}, 32'd0);
        chk("t5_rst_urun",   {31'b0, bus.underrun}, 32'd0);
`ifdef DAC_SCHED_STATS_EN
        chk("t5_rst_stats", bus.sample_count, 32'd0);
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ev_cyc_q.delete();
        repeat (3 * P) @(negedge clk);
        #1;
        chk("t5_no_strobe_after_rst", ev_cyc_q.size(), 0);
        chk("t5_level_after_rst", {28'b0, bus.fifo_level}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
